hyper_evt_router: RTL

- Multi-channel successor to the single-flag HyperBus read/write EOT splitter.
- Per channel, records the direction of each launched transfer (read/write) in a small direction FIFO.
- Tags each end-of-transfer pulse from the HyperBus controller as a read-EOT or write-EOT event, in launch order, so several transfers can be outstanding per channel.
- Sits between the HyperBus controller / uDMA linear channels and the uDMA event lines.

---
 rtl/hyper_evt_router_pkg.sv | 16 +
 rtl/hyper_evt_router_dir_fifo.sv | 62 ++++++
 rtl/hyper_evt_router.sv | 100 ++++++++++
 3 files changed

// File: rtl/hyper_evt_router_pkg.sv
// Shared constants for the HyperBus event router: event slot layout per
// channel and the encoding of a transfer direction in the direction FIFO.
package hyper_evt_pkg;

  // Slot of each event inside a channel's EVT_PER_CH-wide group on evt_o
  localparam int EVT_RX     = 0;
  localparam int EVT_TX     = 1;
  localparam int EVT_RD_EOT = 2;
  localparam int EVT_WR_EOT = 3;
  localparam int EVT_PER_CH = 4;

  // Direction stored per launched transfer
  localparam logic DIR_RD = 1'b1;
  localparam logic DIR_WR = 1'b0;

endpackage

// File: rtl/hyper_evt_router_dir_fifo.sv
// 1-bit-wide direction FIFO. Accepts a push and a pop in the same cycle
// even when full: the head is read out before the freed slot is rewritten.
module hyper_dir_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_din,
  input  logic             i_pop,
  output logic             o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  // Self-protecting: a pop frees the slot a full-FIFO push needs
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  assign o_dout  = r_mem[r_rp];
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/hyper_evt_router.sv
// Per-channel HyperBus EOT tagger: remembers the direction of every launched
// transfer and labels each controller EOT as read- or write-EOT in launch
// order. Launch pulses are forwarded unchanged; all outputs are registered.
module hyper_evt_router
  import hyper_evt_pkg::*;
#(
  parameter int NB_CH      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        sys_clk_i,
  input  logic                        rstn_i,
  input  logic                        clr_i,
  input  logic [NB_CH-1:0]            rx_evt_i,
  input  logic [NB_CH-1:0]            tx_evt_i,
  input  logic [NB_CH-1:0]            eot_i,
  output logic [EVT_PER_CH*NB_CH-1:0] evt_o,
  output logic [CNT_W*NB_CH-1:0]      pending_o,
  output logic [NB_CH-1:0]            ovf_o,
  output logic [NB_CH-1:0]            udf_o,
  output logic [NB_CH-1:0]            amb_o
);

  for (genvar c = 0; c < NB_CH; c++) begin : g_ch
    logic                  w_push;
    logic                  w_din;
    logic                  w_amb;
    logic                  w_pop;
    logic                  w_byp;
    logic                  w_push_ok;
    logic                  w_tag;
    logic                  w_eot_out;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_dout;
    logic [CNT_W-1:0]      w_cnt;
    logic [EVT_PER_CH-1:0] r_evt;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_amb;

    // Exactly one launch line pushes; both together is ambiguous and ignored
    assign w_push = rx_evt_i[c] ^ tx_evt_i[c];
    assign w_din  = rx_evt_i[c] ? DIR_RD : DIR_WR;
    assign w_amb  = rx_evt_i[c] & tx_evt_i[c];

    // EOT pops the head, or on an empty FIFO consumes the same-cycle push
    assign w_pop     = eot_i[c] & ~w_empty;
    assign w_byp     = eot_i[c] & w_empty & w_push;
    assign w_push_ok = w_push & ~w_byp & (~w_full | eot_i[c]);
    assign w_tag     = w_empty ? w_din : w_dout;
    assign w_eot_out = w_pop | w_byp;

    hyper_dir_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .sys_clk_i (sys_clk_i),
      .rstn_i    (rstn_i),
      .i_clr     (clr_i),
      .i_push    (w_push_ok),
      .i_din     (w_din),
      .i_pop     (w_pop),
      .o_dout    (w_dout),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_cnt)
    );

    // Event register and sticky error flags for this channel
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_evt <= '0;
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
        r_amb <= 1'b0;
      end else if (clr_i) begin
        r_evt <= '0;
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
        r_amb <= 1'b0;
      end else begin
        r_evt[EVT_RX]     <= rx_evt_i[c];
        r_evt[EVT_TX]     <= tx_evt_i[c];
        r_evt[EVT_RD_EOT] <= w_eot_out & (w_tag == DIR_RD);
        r_evt[EVT_WR_EOT] <= w_eot_out & (w_tag == DIR_WR);
        if (w_push & w_full & ~eot_i[c]) r_ovf <= 1'b1;
        if (eot_i[c] & w_empty & ~w_push) r_udf <= 1'b1;
        if (w_amb) r_amb <= 1'b1;
      end
    end

    assign evt_o[EVT_PER_CH*c +: EVT_PER_CH] = r_evt;
    assign pending_o[CNT_W*c +: CNT_W]       = w_cnt;
    assign ovf_o[c]                          = r_ovf;
    assign udf_o[c]                          = r_udf;
    assign amb_o[c]                          = r_amb;
  end

endmodule
